sprite_ram_arbiter: RTL and testbench
=====================================

Name: sprite_ram_arbiter

Overview:
Shares the single-port sprite attribute RAM between the stack machine's I/O bus (posted writes) and the video sprite fetcher (reads).
- CPU writes into the sprite window go into a small posted-write FIFO and drain when the video side leaves the RAM idle.
- Video reads have strict priority, with a starvation guard that forces a CPU drain slot.
- A memory-mapped status register exposes FIFO state, because the CPU has no wait/stall input.

Parameters:
DATA_WIDTH, 16, CPU word width (matches `CPU_WIDTH`)
ADDR_WIDTH, 9, sprite RAM address width (512 words)
FIFO_DEPTH, 4, posted-write FIFO entries (power of 2)
BASE_NIBBLE, 4'h8, io_addr[15:12] value selecting the sprite window
MAX_VID_BURST, 8, consecutive video grants allowed while FIFO non-empty before a forced CPU slot

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_addr  in  16  CPU I/O address
io_write  in  1  CPU I/O write strobe, single cycle
io_wr_data  in  16  CPU write data
io_rd_data  out  16  status read data, combinational from io_addr
vid_req  in  1  video read request, held until granted
vid_addr  in  9  video read address
vid_gnt  out  1  video request granted this cycle (combinational)
vid_rd_valid  out  1  vid_rd_data valid (registered, 1 cycle after vid_gnt)
vid_rd_data  out  16  RAM read data for video
ram_addr  out  9  RAM address (combinational)
ram_we  out  1  RAM write enable (combinational)
ram_wr_data  out  16  RAM write data
ram_rd_data  in  16  RAM read data, 1-cycle synchronous latency

Behaviour:
- Decode: win = io_addr[15:12]==BASE_NIBBLE. stat = win && io_addr[11:0]==12'hFFF. data = win && io_addr[11:9]==0.
- Push: io_write && data pushes {io_addr[8:0], io_wr_data}. Accepted if !full, or if a pop occurs in the same cycle.
- Drop: a push that is not accepted is discarded and sets the sticky overflow bit.
- Overflow clear: io_write && stat clears overflow; nothing is pushed. If a drop and a clear occur in the same cycle, the set wins.
- Ignored accesses: writes to window addresses that are neither data nor stat are ignored.
- Status read: io_rd_data = {overflow, full, empty, 10'b0, count[2:0]} when stat, else 16'h0. It is combinational so the CPU's single-cycle LOAD works.
- FSM states are IDLE, VID and CPU_FORCE.
- IDLE:
  - vid_req high: grant video, go to VID.
  - otherwise, FIFO non-empty: pop and write RAM.
- VID:
  - vid_req high: grant video; burst counter increments while the FIFO is non-empty (else it holds at 0).
  - counter reaches MAX_VID_BURST with FIFO non-empty: go to CPU_FORCE.
  - vid_req low: go to IDLE, counter cleared.
- CPU_FORCE:
  - Exactly one cycle: pop and write RAM, vid_gnt=0 even if vid_req is high.
  - Then counter cleared; go to VID if vid_req, else IDLE.
- Video grant cycle: ram_addr=vid_addr, ram_we=0. Next cycle: vid_rd_valid=1, vid_rd_data=ram_rd_data.
- Pop cycle: ram_addr/ram_wr_data come from the FIFO head, ram_we=1.
- Other cycles: ram_we=0, ram_addr=0.
- Same-cycle push + pop: the entry is pushed behind the popped one, count unchanged. A push into an empty FIFO is not drainable until the next cycle, so minimum write latency is 1 cycle.
- Pointers and count wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH, 3 bits.
- Reset, including mid-burst or mid-drain:
  - FSM goes to IDLE; FIFO empty; pointers, count, burst counter and overflow cleared.
  - vid_rd_valid=0, vid_rd_data=0.
  - Any pending FIFO writes are lost.
  - Outputs are 0 while reset is high.

Decomposition:
- Shared package/include holds: state encodings ST_IDLE=2'd0, ST_VID=2'd1, ST_CPU_FORCE=2'd2; status bit positions; status offset 12'hFFF.
- One sub-module: sprite_wr_fifo, a synchronous FIFO (push, pop, head, full, empty, count) of width ADDR_WIDTH+DATA_WIDTH.

Test Plan:
- Write 0x1234 to io_addr 0x8005, no vid_req -> one cycle later ram_we=1, ram_addr=5, ram_wr_data=0x1234; status reads 0x2000.
- Five back-to-back writes while vid_req is held high -> first four accepted. Fifth is dropped, status reads 0xC004. A write to 0x8FFF then makes status read 0x4004.
- vid_req held 20 cycles with 2 FIFO entries -> a CPU_FORCE slot (vid_gnt=0, ram_we=1) follows the 8th video grant, and again after the next 8; FIFO empties.
- vid_req at vid_addr 0x1A0 with RAM holding 0xBEEF -> vid_gnt same cycle, vid_rd_valid=1 with 0xBEEF the next cycle.
- FIFO full, then push and pop in the same cycle -> push accepted, count stays 4, overflow stays 0.
- Assert reset during CPU_FORCE with 3 entries queued -> next cycle status reads 0x2000, ram_we=0, vid_rd_valid=0.

Source files
------------

// File: rtl/sprite_ram_arbiter_pkg.sv
// Shared encodings for the sprite RAM arbiter: FSM states, status register layout, window offsets.
package sprite_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VID       = 2'd1,
    ST_CPU_FORCE = 2'd2
  } arb_state_t;

  localparam int STAT_OVF_BIT   = 15;
  localparam int STAT_FULL_BIT  = 14;
  localparam int STAT_EMPTY_BIT = 13;
  localparam int STAT_CNT_W     = 3;

  localparam logic [11:0] STAT_OFFSET = 12'hFFF;

  function automatic logic [15:0] pack_status(input logic overflow, input logic full,
                                              input logic empty,
                                              input logic [STAT_CNT_W-1:0] count);
    logic [15:0] s;
    s                      = '0;
    s[STAT_OVF_BIT]        = overflow;
    s[STAT_FULL_BIT]       = full;
    s[STAT_EMPTY_BIT]      = empty;
    s[STAT_CNT_W-1:0]      = count;
    return s;
  endfunction

endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// CPU I/O bus, video fetch port and sprite RAM port bundled together.
// master = surrounding system, slave = arbiter.
interface sprite_ram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic [15:0]           io_addr;
  logic                  io_write;
  logic [DATA_WIDTH-1:0] io_wr_data;
  logic [15:0]           io_rd_data;

  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_gnt;
  logic                  vid_rd_valid;
  logic [DATA_WIDTH-1:0] vid_rd_data;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output io_addr, io_write, io_wr_data, vid_req, vid_addr, ram_rd_data,
    input  io_rd_data, vid_gnt, vid_rd_valid, vid_rd_data, ram_addr, ram_we, ram_wr_data
  );

  modport slave (
    input  io_addr, io_write, io_wr_data, vid_req, vid_addr, ram_rd_data,
    output io_rd_data, vid_gnt, vid_rd_valid, vid_rd_data, ram_addr, ram_we, ram_wr_data
  );
endinterface

// File: rtl/sprite_wr_fifo.sv
// Posted-write FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
// Head is visible the cycle after the push (no fall-through).
module sprite_wr_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite RAM shared between video reads (priority, 1-cycle read latency) and posted CPU writes.
// CPU cannot stall: writes into a full FIFO are dropped and flagged in the status register.
module sprite_ram_arbiter
  import sprite_ram_arbiter_pkg::*;
#(
  parameter int         DATA_WIDTH    = 16,
  parameter int         ADDR_WIDTH    = 9,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [3:0] BASE_NIBBLE   = 4'h8,
  parameter int         MAX_VID_BURST = 8
) (
  input logic                  clock,
  input logic                  reset,
  sprite_ram_arbiter_if.slave  bus
);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BURST_W = $clog2(MAX_VID_BURST + 1);

  arb_state_t          state, state_nxt;
  logic [BURST_W-1:0]  burst_cnt, burst_nxt;
  logic                win, stat_sel, data_sel;
  logic                push_req, pop, vid_gnt, overflow, rd_valid_q;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign win      = (bus.io_addr[15:12] == BASE_NIBBLE);
  assign stat_sel = win && (bus.io_addr[11:0] == STAT_OFFSET);
  assign data_sel = win && (bus.io_addr[11:9] == 3'b000);
  assign push_req = !reset && bus.io_write && data_sel;

  sprite_wr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data ({bus.io_addr[ADDR_WIDTH-1:0], bus.io_wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Burst counter only advances while CPU writes are waiting behind video.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      ST_IDLE: begin
        burst_nxt = '0;
        if (bus.vid_req) state_nxt = ST_VID;
      end
      ST_VID: begin
        if (!bus.vid_req) begin
          state_nxt = ST_IDLE;
          burst_nxt = '0;
        end else if (fifo_empty) begin
          burst_nxt = '0;
        end else begin
          burst_nxt = burst_cnt + BURST_W'(1);
          if (burst_nxt == BURST_W'(MAX_VID_BURST)) state_nxt = ST_CPU_FORCE;
        end
      end
      ST_CPU_FORCE: begin
        burst_nxt = '0;
        state_nxt = bus.vid_req ? ST_VID : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    vid_gnt = 1'b0;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.vid_req)      vid_gnt = 1'b1;
        else if (!fifo_empty) pop     = 1'b1;
      end
      ST_VID:       vid_gnt = bus.vid_req;
      ST_CPU_FORCE: pop     = !fifo_empty;
      default: begin
        vid_gnt = 1'b0;
        pop     = 1'b0;
      end
    endcase
    if (reset) begin
      vid_gnt = 1'b0;
      pop     = 1'b0;
    end
  end

  // A dropped push outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= vid_gnt;
      if (push_req && fifo_full && !pop)        overflow <= 1'b1;
      else if (bus.io_write && stat_sel)        overflow <= 1'b0;
    end
  end

  assign bus.vid_gnt      = vid_gnt;
  assign bus.vid_rd_valid = rd_valid_q && !reset;
  assign bus.vid_rd_data  = bus.vid_rd_valid ? bus.ram_rd_data : '0;
  assign bus.ram_we       = pop;
  assign bus.ram_addr     = pop     ? head[ENTRY_W-1:DATA_WIDTH] :
                            vid_gnt ? bus.vid_addr : '0;
  assign bus.ram_wr_data  = pop ? head[DATA_WIDTH-1:0] : '0;
  assign bus.io_rd_data   = (stat_sel && !reset) ?
                            pack_status(overflow, fifo_full, fifo_empty,
                                        STAT_CNT_W'(fifo_count)) : 16'h0;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter: drives one cycle at a time, checks combinational
// outputs 2 time units after the rising edge against hand-computed values.
module tb_sprite_ram_arbiter;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  sprite_ram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

  sprite_ram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [15:0] d,
                       input logic vr);
    bus.io_addr    = a;
    bus.io_write   = w;
    bus.io_wr_data = d;
    bus.vid_req    = vr;
  endtask

  initial begin
    logic [8:0]  exp_addr [4];
    logic [15:0] exp_data [4];
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0);
    bus.vid_addr    = 9'h000;
    bus.ram_rd_data = 16'h0000;
    next_cycle();
    next_cycle();

    // outputs held at zero during reset even with live requests
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
    bus.vid_addr = 9'h055;
    #1;
    chk("rst_gnt",  32'(bus.vid_gnt),    32'h0);
    chk("rst_we",   32'(bus.ram_we),     32'h0);
    chk("rst_addr", 32'(bus.ram_addr),   32'h0);
    chk("rst_stat", 32'(bus.io_rd_data), 32'h0);

    next_cycle();
    reset = 1'b0;
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b0);
    #1;
    chk("idle_stat",  32'(bus.io_rd_data),   32'h2000);
    chk("idle_valid", 32'(bus.vid_rd_valid), 32'h0);

    // single posted write, drained one cycle later
    next_cycle();
    drive(16'h8005, 1'b1, 16'h1234, 1'b0);
    #1;
    chk("wr0_we", 32'(bus.ram_we), 32'h0);
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b0);
    #1;
    chk("wr1_we",   32'(bus.ram_we),      32'h1);
    chk("wr1_addr", 32'(bus.ram_addr),    32'h005);
    chk("wr1_data", 32'(bus.ram_wr_data), 32'h1234);
    chk("wr1_stat", 32'(bus.io_rd_data),  32'h0001);
    next_cycle();
    #1;
    chk("wr2_stat", 32'(bus.io_rd_data), 32'h2000);
    chk("wr2_we",   32'(bus.ram_we),     32'h0);

    // video read with one-cycle RAM latency
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
    bus.vid_addr    = 9'h1A0;
    bus.ram_rd_data = 16'h1111;
    #1;
    chk("vrd_gnt",   32'(bus.vid_gnt),      32'h1);
    chk("vrd_addr",  32'(bus.ram_addr),     32'h1A0);
    chk("vrd_we",    32'(bus.ram_we),       32'h0);
    chk("vrd_vld0",  32'(bus.vid_rd_valid), 32'h0);
    next_cycle();
    bus.vid_req     = 1'b0;
    bus.ram_rd_data = 16'hBEEF;
    #1;
    chk("vrd_vld1",  32'(bus.vid_rd_valid), 32'h1);
    chk("vrd_data",  32'(bus.vid_rd_data),  32'hBEEF);
    chk("vrd_gnt1",  32'(bus.vid_gnt),      32'h0);
    next_cycle();
    bus.ram_rd_data = 16'h0000;
    #1;
    chk("vrd_vld2",  32'(bus.vid_rd_valid), 32'h0);

    // fill under video, drop 5th, clear, then push+pop while full in forced slot
    next_cycle();
    bus.vid_addr = 9'h010;
    drive(16'h8001, 1'b1, 16'hA001, 1'b1);
    #1;
    chk("fill_gnt", 32'(bus.vid_gnt), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      next_cycle();
      drive(16'h8000 + 16'(i), 1'b1, 16'hA000 + 16'(i), 1'b1);
    end
    next_cycle();
    drive(16'h8005, 1'b1, 16'hA005, 1'b1);
    #1;
    chk("nonstat_rd", 32'(bus.io_rd_data), 32'h0);
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
    #1;
    chk("ovf_stat", 32'(bus.io_rd_data), 32'hC004);
    next_cycle();
    drive(16'h8FFF, 1'b1, 16'h0000, 1'b1);
    #1;
    chk("clr_same", 32'(bus.io_rd_data), 32'hC004);
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
    #1;
    chk("clr_stat", 32'(bus.io_rd_data), 32'h4004);
    next_cycle();
    #1;
    chk("burst8_gnt", 32'(bus.vid_gnt), 32'h1);
    chk("burst8_we",  32'(bus.ram_we),  32'h0);
    next_cycle();
    drive(16'h8006, 1'b1, 16'hC006, 1'b1);
    #1;
    chk("force_gnt",  32'(bus.vid_gnt),     32'h0);
    chk("force_we",   32'(bus.ram_we),      32'h1);
    chk("force_addr", 32'(bus.ram_addr),    32'h001);
    chk("force_data", 32'(bus.ram_wr_data), 32'hA001);
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
    #1;
    chk("pp_stat", 32'(bus.io_rd_data), 32'h4004);
    chk("pp_gnt",  32'(bus.vid_gnt),    32'h1);
    // window write that is neither data nor status must be ignored
    next_cycle();
    drive(16'h8A00, 1'b1, 16'hDEAD, 1'b0);
    #1;
    chk("vid_off_we", 32'(bus.ram_we), 32'h0);
    exp_addr = '{9'h002, 9'h003, 9'h004, 9'h006};
    exp_data = '{16'hA002, 16'hA003, 16'hA004, 16'hC006};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(16'h8FFF, 1'b0, 16'h0000, 1'b0);
      #1;
      chk($sformatf("drain%0d_we", i),   32'(bus.ram_we),      32'h1);
      chk($sformatf("drain%0d_addr", i), 32'(bus.ram_addr),    32'(exp_addr[i]));
      chk($sformatf("drain%0d_data", i), 32'(bus.ram_wr_data), 32'(exp_data[i]));
    end
    next_cycle();
    #1;
    chk("drain_stat", 32'(bus.io_rd_data), 32'h2000);
    chk("drain_we",   32'(bus.ram_we),     32'h0);

    // starvation guard: vid_req held 20 cycles, forced slots at cycles 10 and 19
    for (int d = 0; d <= 20; d++) begin
      next_cycle();
      bus.vid_addr = 9'(d);
      if (d == 1)      drive(16'h8010, 1'b1, 16'h1010, 1'b1);
      else if (d == 2) drive(16'h8011, 1'b1, 16'h1011, 1'b1);
      else             drive(16'h8FFF, 1'b0, 16'h0000, d < 20);
      #1;
      chk($sformatf("starve%0d_gnt", d), 32'(bus.vid_gnt),
          (d < 20 && d != 10 && d != 19) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_we", d), 32'(bus.ram_we),
          (d == 10 || d == 19) ? 32'h1 : 32'h0);
      if (d == 10) chk("starve10_addr", 32'(bus.ram_addr), 32'h010);
      if (d == 19) chk("starve19_addr", 32'(bus.ram_addr), 32'h011);
      if (d == 20) chk("starve_stat",   32'(bus.io_rd_data), 32'h2000);
    end
    next_cycle();
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b0);

    // reset asserted during a forced drain with three entries queued
    for (int e = 0; e <= 9; e++) begin
      next_cycle();
      if (e >= 1 && e <= 3) drive(16'h8020 + 16'(e), 1'b1, 16'hE000 + 16'(e), 1'b1);
      else                  drive(16'h8FFF, 1'b0, 16'h0000, 1'b1);
      #1;
      if (e == 9) chk("pre_rst_stat", 32'(bus.io_rd_data), 32'h0003);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rstf_we",  32'(bus.ram_we),       32'h0);
    chk("rstf_gnt", 32'(bus.vid_gnt),      32'h0);
    chk("rstf_vld", 32'(bus.vid_rd_valid), 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(16'h8FFF, 1'b0, 16'h0000, 1'b0);
    #1;
    chk("post_rst_stat", 32'(bus.io_rd_data),   32'h2000);
    chk("post_rst_we",   32'(bus.ram_we),       32'h0);
    chk("post_rst_vld",  32'(bus.vid_rd_valid), 32'h0);
    next_cycle();
    #1;
    chk("post_rst_we2",  32'(bus.ram_we),       32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
